// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter
//   Shares the single external SRAM port between the VGA frame reader (req 0),
//   the milestone-1 upsampler/CSC (req 1) and the milestone-2 IDCT unit (req 2).
//   VGA always wins. M1 and M2 take turns in bounded bursts of up to BURST_MAX
//   grants. Every read is tagged so that the returning word is flagged for the
//   requester that issued it, READ_LATENCY+1 cycles after the grant.
//
// Parameters
//   READ_LATENCY  cycles from SRAM address driven to SRAM_read_data_i valid (1..4)
//   BURST_MAX     max consecutive M1/M2 grants to one owner (1..255)
//
// Ports
//   CLOCK_50_I, Resetn          clock, asynchronous active-low reset
//   req_i/we_n_i/addr_i/wdata_i per-requester access request (index 0 VGA, 1 M1, 2 M2)
//   grant_o                     one-hot, combinational: access accepted this cycle
//   rdata_valid_o, rdata_o      one-hot read-data owner flag, SRAM data pass-through
//   SRAM_address_o/_write_data_o/_we_n_o  registered SRAM command
//   SRAM_read_data_i            data returned by the SRAM controller
//   owner_o                     current burst owner: 0 none, 1 M1, 2 M2
//
// Optional build macro SRAM_ARB_STATS_EN adds stats_clear_i, grant_count_o and
// stall_count_o (saturating per-requester grant and stall cycle counters).
module sram_access_arbiter #(
  parameter int READ_LATENCY = 2,
  parameter int BURST_MAX    = 8
) (
  input  logic             CLOCK_50_I,
  input  logic             Resetn,
  input  logic [2:0]       req_i,
  input  logic [2:0]       we_n_i,
  input  logic [2:0][17:0] addr_i,
  input  logic [2:0][15:0] wdata_i,
  output logic [2:0]       grant_o,
  output logic [2:0]       rdata_valid_o,
  output logic [15:0]      rdata_o,
  output logic [17:0]      SRAM_address_o,
  output logic [15:0]      SRAM_write_data_o,
  output logic             SRAM_we_n_o,
  input  logic [15:0]      SRAM_read_data_i,
  output logic [1:0]       owner_o
`ifdef SRAM_ARB_STATS_EN
  ,
  input  logic             stats_clear_i,
  output logic [2:0][15:0] grant_count_o,
  output logic [2:0][15:0] stall_count_o
`endif
);

  typedef enum logic [1:0] {
    S_NONE = 2'd0,
    S_M1   = 2'd1,
    S_M2   = 2'd2
  } owner_e;

  localparam logic [7:0] BURST_MAX_C = 8'(BURST_MAX);

  owner_e                     owner_q, owner_d;
  owner_e                     rr_last_q, rr_last_d;
  logic [7:0]                 burst_cnt_q, burst_cnt_d;
  logic [2:0]                 grant_s;
  logic [1:0]                 sel_s;
  logic [17:0]                sram_addr_q, sram_addr_d;
  logic [15:0]                sram_wdata_q, sram_wdata_d;
  logic                       sram_we_n_q, sram_we_n_d;
  logic [READ_LATENCY:0]      tag_vld_q, tag_vld_d;
  logic [READ_LATENCY:0][1:0] tag_id_q, tag_id_d;
  logic [2:0]                 rdata_valid_s;

  // Arbitration: VGA first, then the running M burst, then round-robin hand-over.
  // A VGA cycle leaves owner and burst count untouched, so the burst resumes after it.
  always_comb begin
    grant_s     = 3'b000;
    sel_s       = 2'd0;
    owner_d     = owner_q;
    rr_last_d   = rr_last_q;
    burst_cnt_d = burst_cnt_q;
    if (req_i[0]) begin
      grant_s = 3'b001;
      sel_s   = 2'd0;
    end else if ((owner_q == S_M1) && req_i[1] && (burst_cnt_q < BURST_MAX_C)) begin
      grant_s     = 3'b010;
      sel_s       = 2'd1;
      burst_cnt_d = burst_cnt_q + 8'd1;
    end else if ((owner_q == S_M2) && req_i[2] && (burst_cnt_q < BURST_MAX_C)) begin
      grant_s     = 3'b100;
      sel_s       = 2'd2;
      burst_cnt_d = burst_cnt_q + 8'd1;
    end else if (req_i[1] && (!req_i[2] || (rr_last_q == S_M2))) begin
      // A lone requester is regranted even if it just exhausted its burst.
      grant_s     = 3'b010;
      sel_s       = 2'd1;
      owner_d     = S_M1;
      rr_last_d   = S_M1;
      burst_cnt_d = 8'd1;
    end else if (req_i[2]) begin
      grant_s     = 3'b100;
      sel_s       = 2'd2;
      owner_d     = S_M2;
      rr_last_d   = S_M2;
      burst_cnt_d = 8'd1;
    end else begin
      owner_d     = S_NONE;
      burst_cnt_d = 8'd0;
    end
  end

  // SRAM command capture: idle cycles deassert write but keep address and data.
  always_comb begin
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    sram_we_n_d  = 1'b1;
    if (grant_s != 3'b000) begin
      sram_addr_d  = addr_i[sel_s];
      sram_wdata_d = wdata_i[sel_s];
      sram_we_n_d  = we_n_i[sel_s];
    end else begin
      sram_we_n_d  = 1'b1;
    end
  end

  // Read tag pipeline: stage 0 holds the access issued last cycle, the last stage
  // lines up with the SRAM data. Writes and idle cycles enter as invalid.
  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    tag_vld_d[0] = (grant_s != 3'b000) && we_n_i[sel_s];
    tag_id_d[0]  = sel_s;
    for (int k = 1; k <= READ_LATENCY; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end
  end

  // Decode the tag at the end of the pipeline into a one-hot valid flag.
  always_comb begin
    rdata_valid_s = 3'b000;
    if (tag_vld_q[READ_LATENCY]) begin
      case (tag_id_q[READ_LATENCY])
        2'd0:    rdata_valid_s = 3'b001;
        2'd1:    rdata_valid_s = 3'b010;
        2'd2:    rdata_valid_s = 3'b100;
        default: rdata_valid_s = 3'b000;
      endcase
    end else begin
      rdata_valid_s = 3'b000;
    end
  end

  // Owner FSM, SRAM command registers and read tag pipeline.
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      owner_q      <= S_NONE;
      rr_last_q    <= S_M2;
      burst_cnt_q  <= 8'd0;
      sram_addr_q  <= 18'd0;
      sram_wdata_q <= 16'd0;
      sram_we_n_q  <= 1'b1;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
    end else begin
      owner_q      <= owner_d;
      rr_last_q    <= rr_last_d;
      burst_cnt_q  <= burst_cnt_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      sram_we_n_q  <= sram_we_n_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
    end
  end

  assign grant_o           = grant_s;
  assign rdata_valid_o     = rdata_valid_s;
  assign rdata_o           = SRAM_read_data_i;
  assign SRAM_address_o    = sram_addr_q;
  assign SRAM_write_data_o = sram_wdata_q;
  assign SRAM_we_n_o       = sram_we_n_q;
  assign owner_o           = owner_q;

`ifdef SRAM_ARB_STATS_EN
  logic [2:0][15:0] grant_cnt_q, grant_cnt_d;
  logic [2:0][15:0] stall_cnt_q, stall_cnt_d;

  // Saturating per-requester grant and stall counters.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    for (int r = 0; r < 3; r++) begin
      if (stats_clear_i) begin
        grant_cnt_d[r] = 16'd0;
        stall_cnt_d[r] = 16'd0;
      end else begin
        if (grant_s[r] && (grant_cnt_q[r] != 16'hFFFF)) begin
          grant_cnt_d[r] = grant_cnt_q[r] + 16'd1;
        end else begin
          grant_cnt_d[r] = grant_cnt_q[r];
        end
        if (req_i[r] && !grant_s[r] && (stall_cnt_q[r] != 16'hFFFF)) begin
          stall_cnt_d[r] = stall_cnt_q[r] + 16'd1;
        end else begin
          stall_cnt_d[r] = stall_cnt_q[r];
        end
      end
    end
  end

  // Statistics counter registers.
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign grant_count_o = grant_cnt_q;
  assign stall_count_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Testbench for sram_access_arbiter: a cycle model of the arbitration rules and
// read-return schedule checked on every falling edge, plus directed scenarios
// with hand-computed literal expectations.
module tb_sram_access_arbiter;
  localparam int RL = 2;
  localparam int BM = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       req, we_n;
  logic [2:0][17:0] addr;
  logic [2:0][15:0] wdata;
  logic [2:0]       grant, rv;
  logic [15:0]      rdata, sram_wd, sram_rd;
  logic [17:0]      sram_addr;
  logic             sram_we_n;
  logic [1:0]       owner;
`ifdef SRAM_ARB_STATS_EN
  logic             stats_clear = 1'b0;
  logic [2:0][15:0] grant_count, stall_count;
`endif

  always #5 clk = ~clk;

  sram_access_arbiter #(.READ_LATENCY(RL), .BURST_MAX(BM)) dut (
    .CLOCK_50_I(clk), .Resetn(rst_n), .req_i(req), .we_n_i(we_n),
    .addr_i(addr), .wdata_i(wdata), .grant_o(grant), .rdata_valid_o(rv),
    .rdata_o(rdata), .SRAM_address_o(sram_addr), .SRAM_write_data_o(sram_wd),
    .SRAM_we_n_o(sram_we_n), .SRAM_read_data_i(sram_rd), .owner_o(owner)
`ifdef SRAM_ARB_STATS_EN
    , .stats_clear_i(stats_clear), .grant_count_o(grant_count), .stall_count_o(stall_count)
`endif
  );

  // SRAM emulator: word is a fixed function of the address seen RL cycles earlier.
  function automatic logic [15:0] emu_word(input logic [17:0] a);
    return a[15:0] ^ 16'h5A5A ^ {a[17:16], 14'd0};
  endfunction

  logic [17:0] apipe [0:3];
  always @(posedge clk) begin
    apipe[0] <= sram_addr;
    for (int k = 1; k < 4; k++) apipe[k] <= apipe[k-1];
  end
  assign sram_rd = emu_word(apipe[RL-1]);

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model state
  int          m_owner, m_run, m_last;
  logic [17:0] m_addr;
  logic [15:0] m_wd;
  logic        m_we;
  int          pend_id [int];
  logic [17:0] pend_addr [int];

  // Compare process: check DUT against the model, then advance the model one edge.
  always @(negedge clk) begin
    int         eg;
    bit         cont;
    logic [2:0] eg_vec, exp_rv;
    if (!rst_n) begin
      m_owner = 0; m_run = 0; m_last = 2;
      m_addr = 18'd0; m_wd = 16'd0; m_we = 1'b1;
      pend_id.delete(); pend_addr.delete();
    end
    eg = -1; cont = 1'b0;
    if (req[0]) eg = 0;
    else if (m_owner != 0 && req[m_owner] && m_run < BM) begin eg = m_owner; cont = 1'b1; end
    else if (req[1] && req[2]) eg = 3 - m_last;
    else if (req[1]) eg = 1;
    else if (req[2]) eg = 2;
    eg_vec = 3'b000;
    if (eg >= 0) eg_vec[eg] = 1'b1;
    exp_rv = 3'b000;
    if (pend_id.exists(cyc)) exp_rv[pend_id[cyc]] = 1'b1;

    chk("grant", grant, eg_vec);
    chk("owner", owner, m_owner);
    chk("rdata_valid", rv, exp_rv);
    chk("sram_addr", sram_addr, m_addr);
    chk("sram_wdata", sram_wd, m_wd);
    chk("sram_we_n", sram_we_n, m_we);
    chk("rdata_passthru", rdata, sram_rd);
    if (pend_id.exists(cyc)) begin
      chk("rdata_word", rdata, emu_word(pend_addr[cyc]));
      pend_id.delete(cyc); pend_addr.delete(cyc);
    end

    if (rst_n) begin
      if (eg > 0 && cont) m_run++;
      else if (eg > 0) begin m_owner = eg; m_last = eg; m_run = 1; end
      else if (eg < 0) begin m_owner = 0; m_run = 0; end
      if (eg >= 0) begin
        m_addr = addr[eg]; m_wd = wdata[eg]; m_we = we_n[eg];
        if (we_n[eg]) begin
          pend_id[cyc + 1 + RL]   = eg;
          pend_addr[cyc + 1 + RL] = addr[eg];
        end
      end else begin
        m_we = 1'b1;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [2:0] r, input logic [2:0] w);
    req = r; we_n = w;
  endtask

  logic [2:0] mix_req [16] = '{3'b010, 3'b110, 3'b111, 3'b100, 3'b000, 3'b011, 3'b110, 3'b110,
                               3'b101, 3'b010, 3'b000, 3'b100, 3'b110, 3'b001, 3'b111, 3'b010};
  logic [2:0] mix_we  [16] = '{3'b111, 3'b101, 3'b110, 3'b011, 3'b111, 3'b111, 3'b001, 3'b111,
                               3'b010, 3'b101, 3'b111, 3'b111, 3'b011, 3'b110, 3'b111, 3'b111};

  initial begin
    rst_n = 1'b0; req = 3'b000; we_n = 3'b111; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_we_n", sram_we_n, 1'b1);
    chk("rst_owner", owner, 2'd0);
    chk("rst_grant", grant, 3'b000);
    chk("rst_rv", rv, 3'b000);
    chk("rst_addr", sram_addr, 18'd0);
    tick(); rst_n = 1'b1;
    tick();

    // Latency: VGA read of 0x12345
    addr[0] = 18'h12345; drive(3'b001, 3'b111);
    @(negedge clk); chk("lat_grant", grant, 3'b001);
    tick(); drive(3'b000, 3'b111);
    @(negedge clk); chk("lat_addr", sram_addr, 18'h12345); chk("lat_rv_n1", rv, 3'b000);
    @(negedge clk); chk("lat_rv_n2", rv, 3'b000);
    @(negedge clk); chk("lat_rv_n3", rv, 3'b001); chk("lat_rdata", rdata, 16'h391F);
    @(negedge clk); chk("lat_rv_n4", rv, 3'b000);

    // Write path: M2 write 0xBEEF to 0x3FFFF
    tick(); addr[2] = 18'h3FFFF; wdata[2] = 16'hBEEF; drive(3'b100, 3'b011);
    @(negedge clk); chk("wr_grant", grant, 3'b100);
    tick(); drive(3'b000, 3'b111);
    @(negedge clk);
    chk("wr_we_n", sram_we_n, 1'b0); chk("wr_addr", sram_addr, 18'h3FFFF); chk("wr_data", sram_wd, 16'hBEEF);
    repeat (4) begin @(negedge clk); chk("wr_no_rv", rv, 3'b000); end

    // Priority: M1 owns a 3-grant burst, then VGA preempts for 10 cycles
    tick(); addr[1] = 18'h00200; drive(3'b010, 3'b111);
    repeat (3) tick();
    drive(3'b111, 3'b111);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); chk("prio_grant", grant, 3'b001); chk("prio_owner", owner, 2'd1);
      tick();
    end
    drive(3'b110, 3'b111);
    @(negedge clk); chk("prio_resume", grant, 3'b010);
    repeat (12) tick();
    drive(3'b000, 3'b111); repeat (4) tick();

    // Burst rotation from reset
    rst_n = 1'b0; tick(); tick();
    rst_n = 1'b1; drive(3'b110, 3'b111);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      chk("rot_grant", grant, ((k / 8) % 2 == 0) ? 3'b010 : 3'b100);
      chk("rot_owner", owner, (k == 0) ? 2'd0 : ((((k - 1) / 8) % 2 == 0) ? 2'd1 : 2'd2));
      tick();
    end

    // Solo M2 burst: no bubble at burst boundaries
    drive(3'b100, 3'b111);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); chk("solo_grant", grant, 3'b100);
      tick();
    end

    // Owner drop: M2 owns, both request, then M2 drops and M1 takes the same cycle
    drive(3'b110, 3'b111); repeat (2) tick();
    drive(3'b010, 3'b111);
    @(negedge clk); chk("drop_grant", grant, 3'b010);
    tick();

    // Directed mix of reads and writes
    for (int k = 0; k < 16; k++) begin
      for (int r = 0; r < 3; r++) begin
        addr[r]  = 18'(k * 4099 + r * 131);
        wdata[r] = 16'(k * 257 + r);
      end
      drive(mix_req[k], mix_we[k]);
      tick();
    end
    drive(3'b000, 3'b111); repeat (4) tick();

    // Reset mid-read: M1 read of 0x00100 must never return
    addr[1] = 18'h00100; drive(3'b010, 3'b111);
    @(negedge clk); chk("mr_grant", grant, 3'b010);
    tick(); drive(3'b000, 3'b111); rst_n = 1'b0;
    @(negedge clk); chk("mr_rst_we_n", sram_we_n, 1'b1);
    tick(); rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("mr_rv", rv, 3'b000); chk("mr_we_n", sram_we_n, 1'b1); chk("mr_owner", owner, 2'd0);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
